// File: rtl/gate_slice_pkg.sv
// Shared op and FSM state encodings for the sliced gate engine.
// GATE_SLICE_LUT_EN enables the programmable truth-table op (OP_LUT).
package gate_slice_pkg;

  typedef enum logic [2:0] {
    OP_ANDN = 3'd0,
    OP_NAND = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_LUT  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

`ifdef GATE_SLICE_LUT_EN
  localparam bit LUT_EN = 1'b1;
`else
  localparam bit LUT_EN = 1'b0;
`endif

endpackage

// File: rtl/gate_slice_alu.sv
// Combinational SLICE-bit gate function; OP_LUT honoured only with GATE_SLICE_LUT_EN.
module gate_slice_alu
  import gate_slice_pkg::*;
#(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  op_e              op_i,
  input  logic [3:0]       lut_i,
  output logic [SLICE-1:0] r_o
);

`ifndef GATE_SLICE_LUT_EN
  logic unused_lut;
  assign unused_lut = ^lut_i;
`endif

  always_comb begin
    r_o = '0;
    case (op_i)
      OP_ANDN: r_o = ~a_i & b_i;
      OP_NAND: r_o = ~a_i | ~b_i;
      OP_AND:  r_o = a_i & b_i;
      OP_OR:   r_o = a_i | b_i;
      OP_XOR:  r_o = a_i ^ b_i;
      OP_NOR:  r_o = ~(a_i | b_i);
      OP_XNOR: r_o = ~(a_i ^ b_i);
      OP_LUT: begin
`ifdef GATE_SLICE_LUT_EN
        // lut index is {a,b}: index 3 is a=1,b=1
        for (int i = 0; i < SLICE; i++) r_o[i] = lut_i[{a_i[i], b_i[i]}];
`else
        r_o = '0;
`endif
      end
      default: r_o = '0;
    endcase
  end

endmodule

// File: rtl/gate_slice_engine.sv
// Multi-cycle bitwise gate engine: SLICE bits per cycle, valid/ready in and out.
// Optional OP_LUT support via GATE_SLICE_LUT_EN; otherwise op 7 yields zero and sets err.
module gate_slice_engine
  import gate_slice_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  input  logic [3:0]       lut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic             err
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  op_e               op_q, op_d;
  logic [3:0]        lut_q, lut_d;
  logic              zero_q, zero_d, ones_q, ones_d, err_q, err_d;
  logic [SLICE-1:0]  a_sl, b_sl, r_sl;

  assign a_sl = a_q[k_q*SLICE +: SLICE];
  assign b_sl = b_q[k_q*SLICE +: SLICE];

  gate_slice_alu #(.SLICE(SLICE)) u_alu (
    .a_i   (a_sl),
    .b_i   (b_sl),
    .op_i  (op_q),
    .lut_i (lut_q),
    .r_o   (r_sl)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    lut_d   = lut_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = x;
          b_d     = y;
          op_d    = op_e'(op);
          lut_d   = lut;
          res_d   = '0;
          k_d     = '0;
          zero_d  = 1'b0;
          ones_d  = 1'b0;
          err_d   = (op == OP_LUT) && !LUT_EN;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[k_q*SLICE +: SLICE] = r_sl;
        k_d = k_q + 1'b1;
        if (k_q == KW'(N - 1)) begin
          // flags come from the fully assembled word, including this last slice
          zero_d  = (res_d == '0);
          ones_d  = &res_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ANDN;
      lut_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ones_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      lut_q   <= lut_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ones_q  <= ones_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign err       = err_q;

endmodule

// File: tb/tb_gate_slice_engine.sv
// Scoreboard bench for gate_slice_engine: directed vectors on the 8/2 default, random sweeps on 16/4 and 8/8.
module tb_gate_slice_engine;

`ifdef GATE_SLICE_LUT_EN
  localparam bit LUT_EN = 1'b1;
`else
  localparam bit LUT_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        o;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] l, input int w);
    logic [15:0] r;
    logic [15:0] mask;
    mask = 16'hFFFF >> (16 - w);
    case (o)
      3'd0: r = ~a & b;
      3'd1: r = ~a | ~b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      3'd6: r = ~(a ^ b);
      default: begin
        r = '0;
        if (LUT_EN) for (int i = 0; i < 16; i++) r[i] = l[{a[i], b[i]}];
      end
    endcase
    return r & mask;
  endfunction

  // ---------------- main DUT, default parameters ----------------
  logic       rst, in_valid, in_ready, out_valid, out_ready, zero, ones, err;
  logic [7:0] x, y, result;
  logic [2:0] op;
  logic [3:0] lut;

  gate_slice_engine u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .op(op), .lut(lut),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .ones(ones), .err(err)
  );

  exp_t mq[$];
  int   acc_cyc = 0;
  bit   ov_seen = 1'b0;

  always @(negedge clk) begin
    if (out_valid && !ov_seen) chk("latency", cyc - acc_cyc, 4);
    ov_seen = out_valid;
    if (out_valid && out_ready) begin
      if (mq.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        exp_t e;
        e = mq.pop_front();
        chk("result", {24'h0, result}, {16'h0, e.res});
        chk("zero", zero, e.z);
        chk("ones", ones, e.o);
        chk("err", err, e.e);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic [3:0] l,
                       input bit push, input logic [7:0] er, input logic ez, input logic eo, input logic ee);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    x = a; y = b; op = o; lut = l; in_valid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        if (push) mq.push_back('{{8'h0, er}, ez, eo, ee});
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        x = ~a; y = ~b; op = ~o; lut = ~l;  // must be ignored after accept
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && mq.size() != 0; i++) @(negedge clk);
    chk("drain_empty", mq.size(), 0);
  endtask

  // ---------------- parameter sweeps ----------------
  logic sw_rst;
  initial begin
    sw_rst = 1'b1;
    #40 sw_rst = 1'b0;
  end

  for (genvar g = 0; g < 2; g++) begin : sw
    localparam int W  = (g == 0) ? 16 : 8;
    localparam int S  = (g == 0) ? 4 : 8;
    localparam int NN = W / S;
    logic         iv, ir, ov, sz, so, se;
    logic [W-1:0] sx, sy, sres;
    logic [2:0]   sop;
    logic [3:0]   slut;
    exp_t         q[$];
    int           acc = 0;
    bit           seen = 1'b0;
    bit           done = 1'b0;

    gate_slice_engine #(.WIDTH(W), .SLICE(S)) u_sw (
      .clk(clk), .rst(sw_rst), .in_valid(iv), .in_ready(ir), .x(sx), .y(sy), .op(sop), .lut(slut),
      .out_valid(ov), .out_ready(1'b1), .result(sres), .zero(sz), .ones(so), .err(se)
    );

    always @(negedge clk) begin
      if (ov && !seen) chk("sw_latency", cyc - acc, NN);
      seen = ov;
      if (ov) begin
        if (q.size() == 0) chk("sw_unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sw_result", 32'(sres), 32'(e.res));
          chk("sw_zero", sz, e.z);
          chk("sw_ones", so, e.o);
          chk("sw_err", se, e.e);
        end
      end
    end

    initial begin
      iv = 1'b0; sx = '0; sy = '0; sop = '0; slut = '0;
      repeat (6) @(posedge clk);
      for (int n = 0; n < 200; n++) begin
        bit got;
        logic [15:0] r;
        got = 1'b0;
        @(posedge clk);
        #1;
        sx = W'($urandom()); sy = W'($urandom()); sop = 3'($urandom()); slut = 4'($urandom());
        iv = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge clk);
          if (ir) begin
            got = 1'b1;
            r = model(sop, 16'(sx), 16'(sy), slut, W);
            q.push_back('{r, r == 16'h0, r == (16'hFFFF >> (16 - W)), (sop == 3'd7) && !LUT_EN});
            @(posedge clk);
            #1;
            acc = cyc;
            iv  = 1'b0;
          end
        end
        if (!got) chk("sw_accept_timeout", 0, 1);
      end
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      chk("sw_drain_empty", q.size(), 0);
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0; op = '0; lut = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zero, ones, err}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    issue(3'd0, 8'hF0, 8'h3C, 4'h0, 1, 8'h0C, 0, 0, 0);
    drain();
    issue(3'd1, 8'hF0, 8'h3C, 4'h0, 1, 8'hCF, 0, 0, 0);
    issue(3'd4, 8'hA5, 8'hA5, 4'h0, 1, 8'h00, 1, 0, 0);
    drain();

    out_ready = 1'b0;
    issue(3'd1, 8'h00, 8'h00, 4'h0, 1, 8'hFF, 0, 1, 0);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, 8'hFF);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready_same", in_ready, 0);
    @(negedge clk);
    chk("release_in_ready_next", in_ready, 1);

    issue(3'd7, 8'hF0, 8'h3C, 4'b0110, 1, LUT_EN ? 8'hCC : 8'h00, !LUT_EN, 0, !LUT_EN);
    drain();

    issue(3'd2, 8'h12, 8'h34, 4'h0, 0, 8'h00, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_in_ready", in_ready, 1);
    issue(3'd2, 8'hFF, 8'h0F, 4'h0, 1, 8'h0F, 0, 0, 0);
    drain();

    for (int i = 0; i < 10000 && !(sw[0].done && sw[1].done); i++) @(posedge clk);
    chk("sweep_complete", {31'h0, sw[0].done && sw[1].done}, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
